// File: rtl/ahb_arb_gen_pkg.sv
// Shared types for the generalised per-slave AHB arbiter: AHB burst/transfer
// encodings, arbitration mode, FSM states and the burst beat-limit helper.
package ahb_arb_gen_pkg;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_type;

    typedef enum logic {
        FIXED_PRIO  = 1'b0,
        ROUND_ROBIN = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST     = 2'd1,
        INCR_OPEN = 2'd2
    } arb_state_t;

    // Zero-based index of the final beat; INCR has no fixed limit
    function automatic logic [3:0] beat_limit(input hburst_type burst);
        case (burst)
            HB_WRAP4,  HB_INCR4:  beat_limit = 4'd3;
            HB_WRAP8,  HB_INCR8:  beat_limit = 4'd7;
            HB_WRAP16, HB_INCR16: beat_limit = 4'd15;
            default:              beat_limit = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational masked priority picker: lowest set request at or above the
// pointer (round-robin, wrapping) or lowest set request overall (fixed).
module ahb_arb_rr_pick
    import ahb_arb_gen_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int MASTER_BIT = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] req,
    input  logic [MASTER_BIT-1:0] ptr,
    input  arb_mode_t             mode,
    output logic [MASTER_NUM-1:0] grant_oh,
    output logic [MASTER_BIT-1:0] grant_idx
);

    int unsigned           base;
    int unsigned           pos;
    logic [MASTER_BIT-1:0] cand;
    logic                  found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        cand      = '0;
        base      = (mode == ROUND_ROBIN) ? int'(ptr) : 0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            pos = base + i;
            if (pos >= MASTER_NUM) pos = pos - MASTER_NUM;
            cand = MASTER_BIT'(pos);
            if (!found && req[cand]) begin
                found          = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter_gen.sv
// Per-slave AHB arbiter with fixed-priority / round-robin policy and burst
// beat tracking. Define ARB_LOCK_EN to add the hlock grant-retention input.
module ahb_slave_arbiter_gen
    import ahb_arb_gen_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int MASTER_BIT = $clog2(MASTER_NUM),
    parameter int BEAT_BIT   = 4
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic [MASTER_NUM-1:0] hreq,
    input  hburst_type            hburst,
    input  htrans_type            htrans,
    input  logic                  hwait,
    input  arb_mode_t             arb_mode,
`ifdef ARB_LOCK_EN
    input  logic [MASTER_NUM-1:0] hlock,
`endif
    output logic [MASTER_NUM-1:0] hgrant,
    output logic                  hsel,
    output logic [MASTER_BIT-1:0] hmaster,
    output logic                  hlast
);

    arb_state_t            state, cur_state, nxt_state, entry_state;
    logic [BEAT_BIT-1:0]   cnt, nxt_cnt, limit;
    logic [MASTER_BIT-1:0] rr_ptr, nxt_ptr, inc_ptr, pick_ptr;
    logic [MASTER_BIT-1:0] nxt_master, pick_idx;
    logic [MASTER_NUM-1:0] nxt_grant, pick_oh;
    logic                  first_q, nxt_first;
    hburst_type            burst_q, live_burst;
    logic                  accept, abort, release_pt, keep_grant;

    ahb_arb_rr_pick #(
        .MASTER_NUM (MASTER_NUM),
        .MASTER_BIT (MASTER_BIT)
    ) u_pick (
        .req       (hreq),
        .ptr       (pick_ptr),
        .mode      (arb_mode),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    assign hsel     = |hgrant;
    assign inc_ptr  = (hmaster == MASTER_BIT'(MASTER_NUM - 1)) ? '0 : hmaster + 1'b1;
    assign pick_ptr = (state == IDLE) ? rr_ptr : inc_ptr;
    assign accept   = ~hwait & ((htrans == HT_NONSEQ) | (htrans == HT_SEQ));
    assign abort    = ~hwait & (htrans == HT_IDLE);

`ifdef ARB_LOCK_EN
    assign keep_grant = hlock[hmaster] & hreq[hmaster];
`else
    assign keep_grant = 1'b0;
`endif

    // hburst is only valid once granted, so the first granted cycle uses it
    // live and the registered state/burst takes over from then on
    always_comb begin
        entry_state = (hburst == HB_INCR) ? INCR_OPEN : BURST;
        live_burst  = first_q ? hburst : burst_q;
        cur_state   = (state != IDLE && first_q) ? entry_state : state;
        limit       = BEAT_BIT'(beat_limit(live_burst));
        case (cur_state)
            BURST:     release_pt = (accept & (cnt == limit)) | abort;
            INCR_OPEN: release_pt = (~hwait & ~hreq[hmaster]) | abort;
            default:   release_pt = 1'b0;
        endcase
        hlast = release_pt;
    end

    always_comb begin
        nxt_state  = cur_state;
        nxt_grant  = hgrant;
        nxt_master = hmaster;
        nxt_cnt    = cnt;
        nxt_ptr    = rr_ptr;
        nxt_first  = 1'b0;
        if (state == IDLE) begin
            if (|pick_oh) begin
                nxt_grant  = pick_oh;
                nxt_master = pick_idx;
                nxt_state  = entry_state;
                nxt_first  = 1'b1;
            end
        end else if (release_pt) begin
            nxt_cnt = '0;
            if (keep_grant) begin
                nxt_state = entry_state;
                nxt_first = 1'b1;
            end else begin
                nxt_ptr = inc_ptr;
                if (|pick_oh) begin
                    nxt_grant  = pick_oh;
                    nxt_master = pick_idx;
                    nxt_state  = entry_state;
                    nxt_first  = 1'b1;
                end else begin
                    nxt_grant  = '0;
                    nxt_master = '0;
                    nxt_state  = IDLE;
                end
            end
        end else if (accept && cnt != '1) begin
            nxt_cnt = cnt + 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state   <= IDLE;
            hgrant  <= '0;
            hmaster <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
            first_q <= 1'b0;
            burst_q <= HB_SINGLE;
        end else begin
            state   <= nxt_state;
            hgrant  <= nxt_grant;
            hmaster <= nxt_master;
            cnt     <= nxt_cnt;
            rr_ptr  <= nxt_ptr;
            first_q <= nxt_first;
            burst_q <= live_burst;
        end
    end

endmodule
